// File: rtl/stopwatch_ascii_reporter.sv
// Formats a snapshot of the four stopwatch BCD digits as "d3d2.d1d0" plus a
// line terminator and streams it byte-by-byte into the UART TX FIFO.
module stopwatch_ascii_reporter #(
  parameter bit EOL_CRLF = 1'b1,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic [3:0] i_d3,
  input  logic [3:0] i_d2,
  input  logic [3:0] i_d1,
  input  logic [3:0] i_d0,
  input  logic       i_tx_full,
  output logic [7:0] o_wr_data,
  output logic       o_wr_uart,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_IDX = EOL_CRLF ? 3'd6 : 3'd5;

  state_t     state;
  logic [2:0] index;
  logic [3:0] snap_d3;
  logic [3:0] snap_d2;
  logic [3:0] snap_d1;
  logic [3:0] snap_d0;
  logic [7:0] data;
  logic       busy;
  logic       done;

  // Values 10-15 map to 'A'-'F' so corrupted BCD remains visible on the line.
  function automatic logic [7:0] encode_digit(input logic [3:0] d);
    logic [7:0] c;
    if (d < 4'd10) c = 8'h30 + {4'h0, d};
    else           c = 8'h37 + {4'h0, d};
    return c;
  endfunction

  function automatic logic [7:0] char_at(
    input logic [2:0] idx,
    input logic [3:0] d3,
    input logic [3:0] d2,
    input logic [3:0] d1,
    input logic [3:0] d0
  );
    logic [7:0] c;
    case (idx)
      3'd0:    c = (BLANK_LZ && (d3 == 4'd0)) ? 8'h20 : encode_digit(d3);
      3'd1:    c = encode_digit(d2);
      3'd2:    c = 8'h2E;
      3'd3:    c = encode_digit(d1);
      3'd4:    c = encode_digit(d0);
      3'd5:    c = EOL_CRLF ? 8'h0D : 8'h0A;
      default: c = 8'h0A;
    endcase
    return c;
  endfunction

  // The data register always holds char[index], so a write can be issued in
  // the same cycle the FIFO reports space without any extra pipeline stage.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      index   <= 3'd0;
      snap_d3 <= 4'd0;
      snap_d2 <= 4'd0;
      snap_d1 <= 4'd0;
      snap_d0 <= 4'd0;
      data    <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (i_start) begin
            snap_d3 <= i_d3;
            snap_d2 <= i_d2;
            snap_d1 <= i_d1;
            snap_d0 <= i_d0;
            index   <= 3'd0;
            data    <= char_at(3'd0, i_d3, i_d2, i_d1, i_d0);
            busy    <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (!i_tx_full) begin
            if (index == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              index <= index + 3'd1;
              data  <= char_at(index + 3'd1, snap_d3, snap_d2, snap_d1, snap_d0);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Full is gated combinationally so no write is ever issued into a full FIFO.
  assign o_wr_uart = busy & ~i_tx_full;
  assign o_wr_data = data;
  assign o_busy    = busy;
  assign o_done    = done;
  assign o_overrun = i_start & (state != IDLE);

endmodule

// File: tb/tb_stopwatch_ascii_reporter.sv
// Scoreboard bench for stopwatch_ascii_reporter: default-parameter instance (a)
// and a BLANK_LZ=1 / EOL_CRLF=0 instance (b) share clock and reset.
module tb_stopwatch_ascii_reporter;

  logic       clk;
  logic       rst_n;

  logic       a_start, a_full;
  logic [3:0] a_d3, a_d2, a_d1, a_d0;
  logic [7:0] a_data;
  logic       a_wr, a_busy, a_done, a_ovr;

  logic       b_start, b_full;
  logic [3:0] b_d3, b_d2, b_d1, b_d0;
  logic [7:0] b_data;
  logic       b_wr, b_busy, b_done, b_ovr;

  logic [7:0] exp_a[$];
  logic [7:0] rx_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] rx_b[$];

  int wr_cnt_a = 0, done_cnt_a = 0, ovr_cnt_a = 0, busy_cnt_a = 0, viol_a = 0, gap_a = 0;
  int wr_cnt_b = 0, done_cnt_b = 0, ovr_cnt_b = 0, busy_cnt_b = 0, viol_b = 0, gap_b = 0;
  logic prev_wr_a = 1'b0, prev_wr_b = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  stopwatch_ascii_reporter dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(a_start),
    .i_d3(a_d3), .i_d2(a_d2), .i_d1(a_d1), .i_d0(a_d0),
    .i_tx_full(a_full), .o_wr_data(a_data), .o_wr_uart(a_wr),
    .o_busy(a_busy), .o_done(a_done), .o_overrun(a_ovr)
  );

  stopwatch_ascii_reporter #(.EOL_CRLF(1'b0), .BLANK_LZ(1'b1)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(b_start),
    .i_d3(b_d3), .i_d2(b_d2), .i_d1(b_d1), .i_d0(b_d0),
    .i_tx_full(b_full), .o_wr_data(b_data), .o_wr_uart(b_wr),
    .o_busy(b_busy), .o_done(b_done), .o_overrun(b_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (a_wr) begin rx_a.push_back(a_data); wr_cnt_a++; end
    if (a_wr && a_full) viol_a++;
    if (a_busy) busy_cnt_a++;
    if (a_done) begin done_cnt_a++; if (!prev_wr_a) gap_a++; end
    if (a_ovr) ovr_cnt_a++;
    prev_wr_a = a_wr;
    if (b_wr) begin rx_b.push_back(b_data); wr_cnt_b++; end
    if (b_wr && b_full) viol_b++;
    if (b_busy) busy_cnt_b++;
    if (b_done) begin done_cnt_b++; if (!prev_wr_b) gap_b++; end
    if (b_ovr) ovr_cnt_b++;
    prev_wr_b = b_wr;
  end

  function automatic logic [7:0] model_digit(input logic [3:0] v);
    if (v <= 4'd9) return 8'd48 + {4'd0, v};
    else           return 8'd65 + {4'd0, v} - 8'd10;
  endfunction

  task automatic expect_line_a(input logic [3:0] d3, d2, d1, d0);
    exp_a.push_back(model_digit(d3));
    exp_a.push_back(model_digit(d2));
    exp_a.push_back(8'h2E);
    exp_a.push_back(model_digit(d1));
    exp_a.push_back(model_digit(d0));
    exp_a.push_back(8'h0D);
    exp_a.push_back(8'h0A);
  endtask

  task automatic expect_line_b(input logic [3:0] d3, d2, d1, d0);
    exp_b.push_back((d3 == 4'd0) ? 8'h20 : model_digit(d3));
    exp_b.push_back(model_digit(d2));
    exp_b.push_back(8'h2E);
    exp_b.push_back(model_digit(d1));
    exp_b.push_back(model_digit(d0));
    exp_b.push_back(8'h0A);
  endtask

  task automatic start_a(input logic [3:0] d3, d2, d1, d0);
    a_d3 = d3; a_d2 = d2; a_d1 = d1; a_d0 = d0;
    expect_line_a(d3, d2, d1, d0);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic start_b(input logic [3:0] d3, d2, d1, d0);
    b_d3 = d3; b_d2 = d2; b_d1 = d1; b_d0 = d0;
    expect_line_b(d3, d2, d1, d0);
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
  endtask

  task automatic wait_done_a(input string name);
    int base = done_cnt_a;
    int k = 0;
    while (done_cnt_a == base && k < 200) begin @(posedge clk); k++; end
    #1;
    n_checks++;
    if (done_cnt_a == base) begin n_fail++; $display("[TB] FAIL %s_timeout: no o_done within 200 cycles", name); end
  endtask

  task automatic wait_done_b(input string name);
    int base = done_cnt_b;
    int k = 0;
    while (done_cnt_b == base && k < 200) begin @(posedge clk); k++; end
    #1;
    n_checks++;
    if (done_cnt_b == base) begin n_fail++; $display("[TB] FAIL %s_timeout: no o_done within 200 cycles", name); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_start = 1'b0; a_full = 1'b0; a_d3 = 4'd0; a_d2 = 4'd0; a_d1 = 4'd0; a_d0 = 4'd0;
    b_start = 1'b0; b_full = 1'b0; b_d3 = 4'd0; b_d2 = 4'd0; b_d1 = 4'd0; b_d0 = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (a_wr !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset_a_wr: got %b want 0", a_wr); end
    n_checks++; if (a_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_a_data: got %h want 00", a_data); end
    n_checks++; if (a_busy !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_a_busy: got %b want 0", a_busy); end
    n_checks++; if (a_done !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_a_done: got %b want 0", a_done); end
    n_checks++; if (a_ovr !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_a_ovr: got %b want 0", a_ovr); end
    n_checks++; if (b_wr !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset_b_wr: got %b want 0", b_wr); end
    n_checks++; if (b_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_b_data: got %h want 00", b_data); end
    n_checks++; if (b_busy !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_b_busy: got %b want 0", b_busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_line();
    int busy0 = busy_cnt_a, done0 = done_cnt_a, ovr0 = ovr_cnt_a;
    logic [7:0] e, g;
    start_a(4'd1, 4'd2, 4'd3, 4'd4);
    @(negedge clk);
    n_checks++; if (a_wr !== 1'b1)    begin n_fail++; $display("[TB] FAIL basic_first_wr: got %b want 1", a_wr); end
    n_checks++; if (a_data !== 8'h31) begin n_fail++; $display("[TB] FAIL basic_first_data: got %h want 31", a_data); end
    wait_done_a("basic");
    n_checks++; if (busy_cnt_a - busy0 != 7) begin n_fail++; $display("[TB] FAIL basic_busy_cycles: got %0d want 7", busy_cnt_a - busy0); end
    n_checks++; if (done_cnt_a - done0 != 1) begin n_fail++; $display("[TB] FAIL basic_done_count: got %0d want 1", done_cnt_a - done0); end
    n_checks++; if (ovr_cnt_a - ovr0 != 0)   begin n_fail++; $display("[TB] FAIL basic_overrun: got %0d want 0", ovr_cnt_a - ovr0); end
    n_checks++; if (a_busy !== 1'b0)         begin n_fail++; $display("[TB] FAIL basic_busy_after: got %b want 0", a_busy); end
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      n_checks++;
      if (rx_a.size() == 0) begin n_fail++; $display("[TB] FAIL basic_byte: got none want %h", e); end
      else begin g = rx_a.pop_front(); if (g !== e) begin n_fail++; $display("[TB] FAIL basic_byte: got %h want %h", g, e); end end
    end
    n_checks++; if (rx_a.size() != 0) begin n_fail++; $display("[TB] FAIL basic_extra_bytes: got %0d want 0", rx_a.size()); end
    rx_a.delete();
  endtask

  task automatic test_blank_lf();
    int busy0 = busy_cnt_b, done0 = done_cnt_b;
    logic [7:0] e, g;
    start_b(4'd0, 4'd5, 4'd0, 4'd9);
    @(negedge clk);
    n_checks++; if (b_data !== 8'h20) begin n_fail++; $display("[TB] FAIL blank_first_data: got %h want 20", b_data); end
    wait_done_b("blank");
    n_checks++; if (busy_cnt_b - busy0 != 6) begin n_fail++; $display("[TB] FAIL blank_busy_cycles: got %0d want 6", busy_cnt_b - busy0); end
    n_checks++; if (done_cnt_b - done0 != 1) begin n_fail++; $display("[TB] FAIL blank_done_count: got %0d want 1", done_cnt_b - done0); end
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      n_checks++;
      if (rx_b.size() == 0) begin n_fail++; $display("[TB] FAIL blank_byte: got none want %h", e); end
      else begin g = rx_b.pop_front(); if (g !== e) begin n_fail++; $display("[TB] FAIL blank_byte: got %h want %h", g, e); end end
    end
    n_checks++; if (rx_b.size() != 0) begin n_fail++; $display("[TB] FAIL blank_extra_bytes: got %0d want 0", rx_b.size()); end
    rx_b.delete();
  endtask

  task automatic test_hex_digit();
    logic [7:0] e, g;
    start_a(4'd7, 4'd6, 4'hB, 4'd0);
    wait_done_a("hex_a");
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      n_checks++;
      if (rx_a.size() == 0) begin n_fail++; $display("[TB] FAIL hex_a_byte: got none want %h", e); end
      else begin g = rx_a.pop_front(); if (g !== e) begin n_fail++; $display("[TB] FAIL hex_a_byte: got %h want %h", g, e); end end
    end
    n_checks++; if (rx_a.size() != 0) begin n_fail++; $display("[TB] FAIL hex_a_extra_bytes: got %0d want 0", rx_a.size()); end
    rx_a.delete();
    start_b(4'hF, 4'd0, 4'hA, 4'd1);
    wait_done_b("hex_b");
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      n_checks++;
      if (rx_b.size() == 0) begin n_fail++; $display("[TB] FAIL hex_b_byte: got none want %h", e); end
      else begin g = rx_b.pop_front(); if (g !== e) begin n_fail++; $display("[TB] FAIL hex_b_byte: got %h want %h", g, e); end end
    end
    n_checks++; if (rx_b.size() != 0) begin n_fail++; $display("[TB] FAIL hex_b_extra_bytes: got %0d want 0", rx_b.size()); end
    rx_b.delete();
  endtask

  task automatic test_stall();
    int busy0 = busy_cnt_a, wr0 = wr_cnt_a, viol0 = viol_a, wr_mid;
    logic [7:0] e, g;
    start_a(4'd1, 4'd2, 4'd3, 4'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (wr_cnt_a - wr0 != 2) begin n_fail++; $display("[TB] FAIL stall_pre_writes: got %0d want 2", wr_cnt_a - wr0); end
    a_full = 1'b1;
    wr_mid = wr_cnt_a;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++; if (wr_cnt_a != wr_mid) begin n_fail++; $display("[TB] FAIL stall_writes_while_full: got %0d want 0", wr_cnt_a - wr_mid); end
    a_full = 1'b0;
    @(negedge clk);
    n_checks++; if (a_wr !== 1'b1)    begin n_fail++; $display("[TB] FAIL stall_resume_wr: got %b want 1", a_wr); end
    n_checks++; if (a_data !== 8'h2E) begin n_fail++; $display("[TB] FAIL stall_resume_data: got %h want 2e", a_data); end
    wait_done_a("stall");
    n_checks++; if (busy_cnt_a - busy0 != 12) begin n_fail++; $display("[TB] FAIL stall_busy_cycles: got %0d want 12", busy_cnt_a - busy0); end
    n_checks++; if (viol_a != viol0)          begin n_fail++; $display("[TB] FAIL stall_write_on_full: got %0d want 0", viol_a - viol0); end
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      n_checks++;
      if (rx_a.size() == 0) begin n_fail++; $display("[TB] FAIL stall_byte: got none want %h", e); end
      else begin g = rx_a.pop_front(); if (g !== e) begin n_fail++; $display("[TB] FAIL stall_byte: got %h want %h", g, e); end end
    end
    n_checks++; if (rx_a.size() != 0) begin n_fail++; $display("[TB] FAIL stall_extra_bytes: got %0d want 0", rx_a.size()); end
    rx_a.delete();
  endtask

  task automatic test_overrun();
    int done0 = done_cnt_a, ovr0 = ovr_cnt_a, wr0 = wr_cnt_a;
    logic [7:0] e, g;
    start_a(4'd1, 4'd2, 4'd3, 4'd4);
    a_d3 = 4'd9; a_d2 = 4'd9; a_d1 = 4'd9; a_d0 = 4'd9;
    repeat (3) begin @(posedge clk); #1; end
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    wait_done_a("overrun");
    repeat (10) begin @(posedge clk); #1; end
    n_checks++; if (ovr_cnt_a - ovr0 != 1)   begin n_fail++; $display("[TB] FAIL overrun_ticks: got %0d want 1", ovr_cnt_a - ovr0); end
    n_checks++; if (done_cnt_a - done0 != 1) begin n_fail++; $display("[TB] FAIL overrun_done_count: got %0d want 1", done_cnt_a - done0); end
    n_checks++; if (wr_cnt_a - wr0 != 7)     begin n_fail++; $display("[TB] FAIL overrun_total_writes: got %0d want 7", wr_cnt_a - wr0); end
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      n_checks++;
      if (rx_a.size() == 0) begin n_fail++; $display("[TB] FAIL overrun_byte: got none want %h", e); end
      else begin g = rx_a.pop_front(); if (g !== e) begin n_fail++; $display("[TB] FAIL overrun_byte: got %h want %h", g, e); end end
    end
    n_checks++; if (rx_a.size() != 0) begin n_fail++; $display("[TB] FAIL overrun_extra_bytes: got %0d want 0", rx_a.size()); end
    rx_a.delete();
  endtask

  task automatic test_back_to_back();
    int ovr0 = ovr_cnt_a, wr0 = wr_cnt_a, done0 = done_cnt_a;
    logic [7:0] e, g;
    start_a(4'd2, 4'd0, 4'd4, 4'd7);
    repeat (7) begin @(posedge clk); #1; end
    n_checks++; if (a_done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_in_done: got %b want 1", a_done); end
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++; if (ovr_cnt_a - ovr0 != 1)   begin n_fail++; $display("[TB] FAIL b2b_done_overrun: got %0d want 1", ovr_cnt_a - ovr0); end
    n_checks++; if (wr_cnt_a - wr0 != 7)     begin n_fail++; $display("[TB] FAIL b2b_no_second_line: got %0d want 7", wr_cnt_a - wr0); end
    n_checks++; if (done_cnt_a - done0 != 1) begin n_fail++; $display("[TB] FAIL b2b_done_count: got %0d want 1", done_cnt_a - done0); end
    n_checks++; if (a_busy !== 1'b0)         begin n_fail++; $display("[TB] FAIL b2b_idle_busy: got %b want 0", a_busy); end
    start_a(4'd3, 4'd3, 4'd0, 4'd0);
    wait_done_a("b2b_next");
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      n_checks++;
      if (rx_a.size() == 0) begin n_fail++; $display("[TB] FAIL b2b_byte: got none want %h", e); end
      else begin g = rx_a.pop_front(); if (g !== e) begin n_fail++; $display("[TB] FAIL b2b_byte: got %h want %h", g, e); end end
    end
    n_checks++; if (rx_a.size() != 0) begin n_fail++; $display("[TB] FAIL b2b_extra_bytes: got %0d want 0", rx_a.size()); end
    rx_a.delete();
  endtask

  task automatic test_mid_reset();
    int wr0 = wr_cnt_a, k = 0, busy0;
    logic [7:0] e, g;
    start_a(4'd1, 4'd2, 4'd3, 4'd4);
    while (wr_cnt_a - wr0 < 4 && k < 50) begin @(posedge clk); k++; end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_wr !== 1'b0)    begin n_fail++; $display("[TB] FAIL midrst_wr: got %b want 0", a_wr); end
    n_checks++; if (a_data !== 8'h00) begin n_fail++; $display("[TB] FAIL midrst_data: got %h want 00", a_data); end
    n_checks++; if (a_busy !== 1'b0)  begin n_fail++; $display("[TB] FAIL midrst_busy: got %b want 0", a_busy); end
    n_checks++; if (a_done !== 1'b0)  begin n_fail++; $display("[TB] FAIL midrst_done: got %b want 0", a_done); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (wr_cnt_a - wr0 != 4) begin n_fail++; $display("[TB] FAIL midrst_writes: got %0d want 4", wr_cnt_a - wr0); end
    for (int i = 0; i < 4; i++) begin
      e = exp_a.pop_front();
      n_checks++;
      if (rx_a.size() == 0) begin n_fail++; $display("[TB] FAIL midrst_partial_byte: got none want %h", e); end
      else begin g = rx_a.pop_front(); if (g !== e) begin n_fail++; $display("[TB] FAIL midrst_partial_byte: got %h want %h", g, e); end end
    end
    exp_a.delete();
    rx_a.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    busy0 = busy_cnt_a;
    start_a(4'd5, 4'd6, 4'd7, 4'd8);
    wait_done_a("midrst_fresh");
    n_checks++; if (busy_cnt_a - busy0 != 7) begin n_fail++; $display("[TB] FAIL midrst_fresh_busy: got %0d want 7", busy_cnt_a - busy0); end
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      n_checks++;
      if (rx_a.size() == 0) begin n_fail++; $display("[TB] FAIL midrst_fresh_byte: got none want %h", e); end
      else begin g = rx_a.pop_front(); if (g !== e) begin n_fail++; $display("[TB] FAIL midrst_fresh_byte: got %h want %h", g, e); end end
    end
    n_checks++; if (rx_a.size() != 0) begin n_fail++; $display("[TB] FAIL midrst_fresh_extra: got %0d want 0", rx_a.size()); end
    rx_a.delete();
  endtask

  task automatic test_global_flags();
    n_checks++; if (viol_a + viol_b != 0) begin n_fail++; $display("[TB] FAIL write_while_full: got %0d want 0", viol_a + viol_b); end
    n_checks++; if (gap_a + gap_b != 0)   begin n_fail++; $display("[TB] FAIL done_not_after_last: got %0d want 0", gap_a + gap_b); end
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_blank_lf();
    test_hex_digit();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_global_flags();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/stopwatch_ascii_reporter.md
Name: stopwatch_ascii_reporter

Overview:
Downstream formatter for the stopwatch datapath. On a start tick it snapshots the four BCD digits and formats them as an ASCII line, "d3d2.d1d0" plus line terminator. It pushes the line byte-by-byte into the UART TX FIFO write port and obeys the FIFO full flag. Sits between the stopwatch digit outputs and the UART write interface (i_wr_uart / i_wr_data).

Parameters:
EOL_CRLF, 1, 1: terminator is CR (0x0D) then LF (0x0A); 0: LF only.
BLANK_LZ, 0, 1: a leading d3 of 0 is sent as space (0x20); 0: sent as '0'.

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_start  input  1  one-cycle request to report the current time
i_d3  input  4  tens-of-seconds digit
i_d2  input  4  seconds digit
i_d1  input  4  tenths digit
i_d0  input  4  hundredths digit
i_tx_full  input  1  UART TX FIFO full
o_wr_data  output  8  ASCII byte to the FIFO
o_wr_uart  output  1  FIFO write strobe, 1 cycle per byte
o_busy  output  1  line in progress
o_done  output  1  1-cycle tick after the last byte is written
o_overrun  output  1  1-cycle tick when i_start is dropped because the block is busy

Behaviour:
- Reset (async, i_reset_n=0): state IDLE, all outputs 0, index 0, snapshot regs 0. Reset mid-line aborts the line with no further writes. No partial-line resume.
- States: IDLE, SEND, DONE.
- IDLE: on i_start=1, latch i_d3..i_d0 into snapshot regs, set index=0, go to SEND. o_busy=1 from the next cycle.
- SEND: each cycle with i_tx_full=0:
  - o_wr_uart=1 and o_wr_data=char[index], registered outputs.
  - Index increments.
  - On the last char, go to DONE.
- SEND with i_tx_full=1: o_wr_uart=0, index holds, o_wr_data holds. Stall has no limit.
- Char sequence:
  - index0 = d3; index1 = d2; index2 = '.' (0x2E); index3 = d1; index4 = d0.
  - index5 = CR when EOL_CRLF=1, else LF.
  - index6 = LF (EOL_CRLF=1 only).
  - Line length 7 or 6 bytes.
- Digit encode: value 0-9 -> 0x30+value. Values 10-15 -> 'A'-'F' (0x41+value-10); out-of-range BCD stays visible.
- BLANK_LZ=1 with snapshot d3=0: index0 = 0x20. Other digits are never blanked.
- DONE: o_done=1 for exactly one cycle, o_busy=0 in the same cycle, then IDLE. A start in the DONE cycle counts as busy (overrun).
- i_start while o_busy=1 or in DONE: ignored, o_overrun=1 for that cycle, snapshot unchanged.
- Snapshot is the only digit source. Digit inputs changing mid-line do not affect output.
- Latency, FIFO never full:
  - i_start sampled at edge N.
  - First o_wr_uart high in cycle N+1.
  - Last byte in cycle N+L (L = line length).
  - o_done in cycle N+L+1.
- o_wr_uart is never asserted in a cycle where i_tx_full=1. FIFO full is sampled in the same cycle as the write decision (combinational gate on the registered next-state).

Test Plan:
- Default params, digits 1,2,3,4, i_start pulse, i_tx_full=0 -> 7 consecutive writes 0x31 0x32 0x2E 0x33 0x34 0x0D 0x0A; o_done one cycle after 0x0A; o_busy high 7 cycles.
- BLANK_LZ=1, EOL_CRLF=0, digits 0,5,0,9 -> 0x20 0x35 0x2E 0x30 0x39 0x0A; 6 writes.
- i_tx_full forced high for 5 cycles after the second byte -> no o_wr_uart during the stall; third byte 0x2E appears on the first cycle full drops; total bytes still 7, no duplicates.
- Digits change from 1,2,3,4 to 9,9,9,9 after start, plus a second i_start at byte 3 -> output still "12.34\r\n"; o_overrun one cycle at the second start; exactly one o_done.
- i_reset_n pulled low after the 4th byte -> all outputs 0 immediately; after release, a new i_start yields a complete fresh line.
- Digit value 4'hB in d1 -> byte index3 = 0x42.
